// File: rtl/conv_window_ctrl.sv
// Sliding-window controller: counts incoming pixels, gates line-buffer shifts and issues KxK window handshakes.
// Optional macro CONV_WINDOW_STRIDE2_EN selects stride-2 window issue (every pixel is still shifted).
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  shift_en,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0] win_row,
  output logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] win_col,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   row, row_off, win_row_q, win_row_next;
  logic [CW-1:0]   col, col_off, win_col_q, win_col_next;
  logic            win_valid_q;
  logic            stall, last_pixel, in_window, win_fire;

  // A pending, unconsumed window freezes the pixel stream so line buffers never move under it.
  assign stall      = win_valid_q && !win_ready;
  assign in_ready   = (state == STREAM) && !stall && !rst;
  assign shift_en   = in_valid && in_ready;
  assign last_pixel = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  assign row_off   = row - RW'(K - 1);
  assign col_off   = col - CW'(K - 1);
  assign in_window = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

`ifdef CONV_WINDOW_STRIDE2_EN
  assign win_fire     = shift_en && in_window && !row_off[0] && !col_off[0];
  assign win_row_next = row_off >> 1;
  assign win_col_next = col_off >> 1;
`else
  assign win_fire     = shift_en && in_window;
  assign win_row_next = row_off;
  assign win_col_next = col_off;
`endif

  assign win_valid = win_valid_q && !rst;
  assign win_row   = rst ? '0 : win_row_q;
  assign win_col   = rst ? '0 : win_col_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (shift_en && last_pixel) state_next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        // Frame ends only once the final window has been taken downstream.
        if (!win_valid_q) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      busy       = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (shift_en) begin
      if (last_pixel) begin
        row <= '0;
        col <= '0;
      end else if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A new window completing in the consuming cycle replaces the old one back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (win_fire) begin
      win_valid_q <= 1'b1;
      win_row_q   <= win_row_next;
      win_col_q   <= win_col_next;
    end else if (win_ready) begin
      win_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: expected windows are queued at frame start and popped on each handshake.
// Define CONV_WINDOW_STRIDE2_EN for both RTL and bench to exercise the stride-2 build.
module tb_conv_window_ctrl;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int TOTAL = IMG_W * IMG_H;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int EXP_WINS = 169;
  localparam int LAST_RC  = 12;
`else
  localparam int EXP_WINS = 676;
  localparam int LAST_RC  = 25;
`endif

  typedef struct {
    int r;
    int c;
  } win_t;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, win_ready;
  logic       in_ready, shift_en, win_valid, busy, frame_done;
  logic [4:0] win_row, win_col;

  win_t exp_q[$];
  int   num_checks = 0;
  int   num_errors = 0;
  int   shift_cnt, win_cnt, fd_cnt, stall_cycles, first_at, last_r, last_c;
  bit   stream_m, seen_win, stall_mode;

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Outputs are sampled mid-cycle, after inputs settled and before the accepting edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_shift_en", shift_en, 0);
      checkOutput("rst_win_valid", win_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_win_row", win_row, 0);
      checkOutput("rst_win_col", win_col, 0);
    end else begin
      automatic bit exp_ir = stream_m && !(win_valid && !win_ready);
      checkOutput("in_ready", in_ready, exp_ir);
      checkOutput("shift_en", shift_en, in_valid && exp_ir);
      if (win_valid && !seen_win) begin
        seen_win = 1;
        first_at = shift_cnt;
      end
      if (win_valid && !win_ready) begin
        stall_cycles++;
        checkOutput("stall_row", win_row, 3);
        checkOutput("stall_col", win_col, 7);
      end
      if (win_valid && win_ready) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("win_unexpected", win_cnt, EXP_WINS);
        end else begin
          automatic win_t e = exp_q.pop_front();
          checkOutput("win_row", win_row, e.r);
          checkOutput("win_col", win_col, e.c);
          last_r = win_row;
          last_c = win_col;
        end
      end
      if (shift_en) begin
        shift_cnt++;
        if (shift_cnt == TOTAL) stream_m = 0;
      end
      if (frame_done) fd_cnt++;
    end
  end

  // mode 0: continuous + stray start, 1: stall at (3,7), 2: random in_valid, 3: abort at (10,4)
  task automatic applyStimulus(input int mode);
    bit done = 0;
    shift_cnt = 0; win_cnt = 0; fd_cnt = 0; stall_cycles = 0;
    first_at = -1; last_r = -1; last_c = -1; seen_win = 0;
    stall_mode = (mode == 1);
    exp_q.delete();
    for (int r = 0; r <= IMG_H - K; r++)
      for (int c = 0; c <= IMG_W - K; c++) begin
`ifdef CONV_WINDOW_STRIDE2_EN
        if (r % 2 == 0 && c % 2 == 0) exp_q.push_back('{r / 2, c / 2});
`else
        exp_q.push_back('{r, c});
`endif
      end
    start = 1; in_valid = 1; win_ready = 1;
    @(posedge clk); #1;
    start = 0;
    stream_m = 1;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      automatic int stall_left = 0;
      in_valid  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      win_ready = 1;
      if (stall_mode && win_valid && win_row == 3 && win_col == 7 && stall_cycles < 5) win_ready = 0;
      start = (mode == 0 && cyc == 100);
      if (mode == 3 && shift_cnt == 10 * IMG_W + 4) begin
        rst = 1;
        stream_m = 0;
        repeat (3) begin
          @(posedge clk); #1;
        end
        rst = 0;
        exp_q.delete();
        checkOutput("abort_frame_done", fd_cnt, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_win_valid", win_valid, 0);
        return;
      end
      @(posedge clk); #1;
      if (mode == 0 && cyc == 100) checkOutput("busy_after_restart", busy, 1);
      if (fd_cnt > 0 && !busy) done = 1;
      stall_left = 0;
    end
    start = 0;
    checkOutput("frame_timeout", done, 1);
    checkOutput("shift_count", shift_cnt, TOTAL);
    checkOutput("win_count", win_cnt, EXP_WINS);
    checkOutput("first_win_at", first_at, (K - 1) * IMG_W + K);
    checkOutput("last_win_row", last_r, LAST_RC);
    checkOutput("last_win_col", last_c, LAST_RC);
    checkOutput("frame_done_count", fd_cnt, 1);
    checkOutput("busy_end", busy, 0);
    checkOutput("queue_left", exp_q.size(), 0);
    checkOutput("stall_cycles", stall_cycles, stall_mode ? 5 : 0);
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 1; win_ready = 1;
    stream_m = 0; seen_win = 0; stall_mode = 0;
    shift_cnt = 0; win_cnt = 0; fd_cnt = 0; stall_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_in_ready", in_ready, 0);
    applyStimulus(0);
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28: pixels per input row.
REQ-002 SHALL have parameter IMG_H, default 28: rows per frame.
REQ-003 SHALL have parameter K, default 3: kernel size; line-buffer depth is IMG_W-K+1 (26 at defaults).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins a frame.
REQ-007 SHALL have port in_valid, input, 1: pixel available upstream.
REQ-008 SHALL have port in_ready, output, 1: controller accepts a pixel this cycle.
REQ-009 SHALL have port shift_en, output, 1: drives shift_en of every line buffer and window register.
REQ-010 SHALL have port win_valid, output, 1: a complete KxK window is present.
REQ-011 SHALL have port win_ready, input, 1: downstream MAC array consumes the window.
REQ-012 SHALL have ports win_row and win_col, output, $clog2(IMG_H) and $clog2(IMG_W) bits: top-left output coordinate of the current window.
REQ-013 SHALL have port busy, output, 1: high from start acceptance until frame_done.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at end of frame.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM and DONE.
REQ-016 IDLE->STREAM SHALL occur on start=1; start SHALL be ignored outside IDLE.
REQ-017 in_ready SHALL equal (state==STREAM) && !(win_valid && !win_ready).
REQ-018 shift_en SHALL equal in_valid && in_ready (combinational); a pixel is accepted only when shift_en=1.
REQ-019 Column counter col SHALL run 0..IMG_W-1 and increment on each accepted pixel; at IMG_W-1 it SHALL wrap to 0 and increment row (0..IMG_H-1).
REQ-020 An accepted pixel at (row,col) with row>=K-1 and col>=K-1 SHALL set win_valid=1 on the next cycle, with win_row=row-(K-1) and win_col=col-(K-1) registered alongside.
REQ-021 win_valid SHALL hold, with win_row and win_col stable, until a cycle with win_ready=1; it SHALL then clear, unless that same cycle accepts a pixel that completes a new window, in which case it SHALL stay 1 with the new coordinates.
REQ-022 No pixel SHALL be accepted and no shift SHALL occur while win_valid=1 and win_ready=0; line buffers SHALL never shift under a pending window.
REQ-023 Accepting pixel (IMG_H-1, IMG_W-1) SHALL move STREAM->DONE and zero row and col.
REQ-024 In DONE, frame_done SHALL pulse for exactly one cycle after win_valid is 0 (last window consumed), followed by DONE->IDLE.
REQ-025 busy SHALL be 1 in STREAM and DONE and 0 in IDLE.
REQ-026 A full frame SHALL produce exactly (IMG_H-K+1)*(IMG_W-K+1) windows (676 at defaults), in raster order.

Reset
REQ-027 While rst=1, the FSM SHALL go to IDLE and row, col, win_row and win_col SHALL be 0.
REQ-028 While rst=1, in_ready, shift_en, win_valid, busy and frame_done SHALL be 0.
REQ-029 Reset mid-frame SHALL abandon the frame, with no frame_done; line-buffer contents are don't-care and are overwritten by the next frame's fill.

Configuration
REQ-030 Macro CONV_WINDOW_STRIDE2_EN SHALL select stride 2 when defined: windows are issued only where (row-(K-1)) and (col-(K-1)) are both even, and win_row and win_col report the output index (coordinate/2).
REQ-031 With CONV_WINDOW_STRIDE2_EN defined, every pixel SHALL still be shifted, and the window count SHALL be 169 at defaults.
REQ-032 Without CONV_WINDOW_STRIDE2_EN, the block SHALL use stride 1 per REQ-020 to REQ-026.

Verification
REQ-033 Defaults, start, in_valid=1 and win_ready=1 continuously -> 784 shifts, 676 win_valid cycles; first window (0,0) one cycle after the 59th accepted pixel; last window (25,25); one frame_done; busy returns to 0.
REQ-034 win_ready held 0 for 5 cycles at window (3,7) -> in_ready=0 and shift_en=0 for those cycles; win_row=3 and win_col=7 stable; no pixel lost; window count stays 676.
REQ-035 in_valid toggled randomly at 50% duty -> identical window sequence and coordinates as REQ-033.
REQ-036 rst asserted at row 10, col 4, then a new start -> all outputs 0 during reset, no frame_done; the next frame yields 676 windows from (0,0).
REQ-037 start pulsed again while busy -> ignored; counters undisturbed.
REQ-038 CONV_WINDOW_STRIDE2_EN defined with REQ-033 stimulus -> 169 windows, last at (12,12); 784 shifts.
